// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the stalling bus RAM responder.
package mips_bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STALL = 2'd1,
      DONE  = 2'd2
   } bus_state_t;

   localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
   localparam int          BUS_WIDTH    = 32;
   localparam int          BE_WIDTH     = 4;

   // Debug view of the responder: FSM state, stall counter and LFSR.
   typedef struct packed {
      bus_state_t  state;
      logic [3:0]  cnt;
      logic [7:0]  lfsr;
   } dbg_t;

endpackage

// File: rtl/mips_bus_ram_stall_if.sv
// Avalon-MM style bus between the CPU initiator and the stalling RAM.
// Handshake: the initiator raises exactly one of read/write together with
// address/writedata/byteenable and must hold all of them stable while
// waitrequest=1; the transfer completes on the first rising clock edge at
// which waitrequest=0, and readdata is valid in that same cycle.
interface mips_bus_ram_stall_if;
   import mips_bus_pkg::*;

   logic [BUS_WIDTH-1:0] address;
   logic                 write;
   logic                 read;
   logic                 waitrequest;
   logic [BUS_WIDTH-1:0] writedata;
   logic [BE_WIDTH-1:0]  byteenable;
   logic [BUS_WIDTH-1:0] readdata;
   logic                 err;

   modport master (
      output address, write, read, writedata, byteenable,
      input  waitrequest, readdata, err
   );

   modport slave (
      input  address, write, read, writedata, byteenable,
      output waitrequest, readdata, err
   );

endinterface

// File: rtl/bus_stall_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that picks random stall lengths.
module bus_stall_lfsr (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] seed,
   output logic [7:0] lfsr
);

   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;

   // Shift left, feedback from taps 8,6,5,4; a nonzero seed never reaches 0.
   always_comb begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   // Advance every cycle; reload the seed on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr_q <= seed;
      else       lfsr_q <= lfsr_d;
   end

   assign lfsr = lfsr_q;

endmodule

// File: rtl/mips_bus_ram_stall.sv
// Stalling memory responder: one word array behind the reset-vector window
// and the low data window, with fixed or LFSR-random waitrequest stalls.
module mips_bus_ram_stall
   import mips_bus_pkg::*;
#(
   parameter logic [31:0] INSTR_BASE   = RESET_VECTOR,
   parameter int          INSTR_WORDS  = 2048,
   parameter int          DATA_WORDS   = 2048,
   parameter int          STALL_MODE   = 0,
   parameter int          STALL_CYCLES = 0,
   parameter logic [3:0]  STALL_MASK   = 4'hF,
   parameter logic [7:0]  SEED         = 8'hA5
) (
   input  logic                  clk,
   input  logic                  reset,
   mips_bus_ram_stall_if.slave   bus,
   output dbg_t                  dbg_o
);

   localparam int          MEM_WORDS   = INSTR_WORDS + DATA_WORDS;
   localparam int          IDX_W       = $clog2(MEM_WORDS);
   localparam logic [31:0] INSTR_BYTES = 32'(4 * INSTR_WORDS);
   localparam logic [31:0] DATA_BYTES  = 32'(4 * DATA_WORDS);
   localparam logic [3:0]  FIXED_STALL = 4'(STALL_CYCLES);

   bus_state_t           state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [31:0]          addr_q;
   logic                 wr_q;
   logic [31:0]          readdata_q;
   logic                 err_q;
   logic [7:0]           lfsr;
   logic [BUS_WIDTH-1:0] mem [MEM_WORDS];

   logic [31:0]          instr_off;
   logic                 in_instr, in_data, aligned, hit;
   logic [IDX_W-1:0]     idx;
   logic                 req_one, req_both, abort;
   logic                 enter_done, set_err, mem_we;
   logic [3:0]           stall_val;

   bus_stall_lfsr u_lfsr (
      .clk   (clk),
      .reset (reset),
      .seed  (SEED),
      .lfsr  (lfsr)
   );

   // Address decode: instruction window wins, then the low data window.
   always_comb begin
      instr_off = bus.address - INSTR_BASE;
      in_instr  = instr_off < INSTR_BYTES;
      in_data   = bus.address < DATA_BYTES;
      aligned   = bus.address[1:0] == 2'b00;
      idx       = '0;
      if (in_instr)     idx = IDX_W'(instr_off >> 2);
      else if (in_data) idx = IDX_W'(INSTR_WORDS) + IDX_W'(bus.address >> 2);
      hit       = aligned && (in_instr || in_data);
   end

   // Next state: accept a single request, count stalls, abort on a broken hold.
   always_comb begin
      req_one    = bus.read ^ bus.write;
      req_both   = bus.read & bus.write;
      stall_val  = (STALL_MODE == 0) ? FIXED_STALL : (lfsr[3:0] & STALL_MASK);
      abort      = !req_one || (bus.write != wr_q) || (bus.address != addr_q);
      state_d    = state_q;
      cnt_d      = cnt_q;
      enter_done = 1'b0;
      set_err    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_both) begin
               set_err = 1'b1;
            end else if (req_one) begin
               if (stall_val != 4'd0) begin
                  cnt_d   = stall_val - 4'd1;
                  state_d = STALL;
               end else begin
                  state_d    = DONE;
                  enter_done = 1'b1;
               end
            end
         end
         STALL: begin
            if (abort) begin
               state_d = IDLE;
               set_err = 1'b1;
            end else if (cnt_q == 4'd0) begin
               state_d    = DONE;
               enter_done = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs: waitrequest drops only in DONE, and always while in reset.
   always_comb begin
      bus.waitrequest = !reset && (bus.read || bus.write) && (state_q != DONE);
      bus.readdata    = readdata_q;
      bus.err         = err_q;
      mem_we          = !reset && enter_done && bus.write && hit;
      dbg_o           = '{state: state_q, cnt: cnt_q, lfsr: lfsr};
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Stall counter, captured request, read data and sticky error flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q      <= 4'd0;
         addr_q     <= '0;
         wr_q       <= 1'b0;
         readdata_q <= '0;
         err_q      <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (state_q == IDLE && req_one) begin
            addr_q <= bus.address;
            wr_q   <= bus.write;
         end
         if (set_err || (enter_done && !hit)) err_q <= 1'b1;
         if (enter_done && bus.read) readdata_q <= hit ? mem[idx] : '0;
      end
   end

   // Byte-lane memory write; contents survive reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
         if (mem_we && bus.byteenable[i]) mem[idx][8*i +: 8] <= bus.writedata[8*i +: 8];
      end
   end

endmodule

// File: tb/tb_mips_bus_ram_stall.sv
// Bench for the stalling bus RAM: three responders (no stall, fixed 3-cycle
// stall, random stall with mask 7) share one set of bus drivers.
module tb_mips_bus_ram_stall;
   import mips_bus_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [31:0] addr_b, wdata_b;
   logic [3:0]  be_b;
   logic        rd_b, wr_b;
   int          sel;

   mips_bus_ram_stall_if bus0 ();
   mips_bus_ram_stall_if bus1 ();
   mips_bus_ram_stall_if bus2 ();
   dbg_t dbg0, dbg1, dbg2;

   assign bus0.address = addr_b;  assign bus0.writedata = wdata_b;  assign bus0.byteenable = be_b;
   assign bus1.address = addr_b;  assign bus1.writedata = wdata_b;  assign bus1.byteenable = be_b;
   assign bus2.address = addr_b;  assign bus2.writedata = wdata_b;  assign bus2.byteenable = be_b;
   assign bus0.read = rd_b && (sel == 0);  assign bus0.write = wr_b && (sel == 0);
   assign bus1.read = rd_b && (sel == 1);  assign bus1.write = wr_b && (sel == 1);
   assign bus2.read = rd_b && (sel == 2);  assign bus2.write = wr_b && (sel == 2);

   mips_bus_ram_stall #(.STALL_MODE(0), .STALL_CYCLES(0)) dut0 (
      .clk(clk), .reset(rst), .bus(bus0), .dbg_o(dbg0));
   mips_bus_ram_stall #(.STALL_MODE(0), .STALL_CYCLES(3)) dut1 (
      .clk(clk), .reset(rst), .bus(bus1), .dbg_o(dbg1));
   mips_bus_ram_stall #(.STALL_MODE(1), .STALL_MASK(4'h7)) dut2 (
      .clk(clk), .reset(rst), .bus(bus2), .dbg_o(dbg2));

   logic        wait_s, err_s;
   logic [31:0] rdata_s;
   dbg_t        dbg_s;
   always_comb begin
      case (sel)
         1:       begin wait_s = bus1.waitrequest; err_s = bus1.err; rdata_s = bus1.readdata; dbg_s = dbg1; end
         2:       begin wait_s = bus2.waitrequest; err_s = bus2.err; rdata_s = bus2.readdata; dbg_s = dbg2; end
         default: begin wait_s = bus0.waitrequest; err_s = bus0.err; rdata_s = bus0.readdata; dbg_s = dbg0; end
      endcase
   end

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_rd [3];
   logic [31:0] pool [8];
   logic [31:0] model [8];

   typedef struct packed {
      logic        is_wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] rdata;
      logic [31:0] waits;
      logic        err;
   } vec_t;
   vec_t tbl [22];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one transfer (call just after a rising edge); returns stall count.
   task automatic bus_op(input logic is_wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output int waits);
      int guard;
      logic [31:0] exp;
      guard = 0;
      waits = 0;
      addr_b = a; wdata_b = d; be_b = be; rd_b = !is_wr; wr_b = is_wr;
      @(negedge clk);
      while (wait_s === 1'b1 && guard < 64) begin
         waits++;
         guard++;
         @(negedge clk);
      end
      if (wait_s !== 1'b0) begin
         check("bus_timeout", {31'd0, wait_s}, 32'd0);
      end else if (!is_wr) begin
         if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
         end else begin
            exp = exp_q.pop_front();
            check("read_data", rdata_s, exp);
            last_rd[sel] = exp;
         end
      end else begin
         check("write_readdata_hold", rdata_s, last_rd[sel]);
      end
      @(posedge clk);
      #1;
      rd_b = 1'b0;
      wr_b = 1'b0;
   endtask

   task automatic apply_reset();
      rd_b = 1'b0;
      wr_b = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) last_rd[i] = '0;
      exp_q.delete();
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          waits;
      int          k;
      logic [31:0] d;
      logic [3:0]  be;
      logic [31:0] m;

      // reset state, including waitrequest forced low under reset
      rst = 1'b1; rd_b = 1'b0; wr_b = 1'b0; addr_b = '0; wdata_b = '0; be_b = '0; sel = 0;
      for (int i = 0; i < 3; i++) last_rd[i] = '0;
      repeat (2) @(posedge clk);
      #1 rd_b = 1'b1;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check($sformatf("rst_wait%0d", s), {31'd0, wait_s}, 32'd0);
         check($sformatf("rst_err%0d", s), {31'd0, err_s}, 32'd0);
         check($sformatf("rst_rdata%0d", s), rdata_s, 32'd0);
         check($sformatf("rst_state%0d", s), 32'(dbg_s.state), 32'(IDLE));
      end
      rd_b = 1'b0;
      sel = 0;
      @(posedge clk);
      #1 rst = 1'b0;

      // vectors on the zero-stall responder
      tbl[0]  = '{1'b1, 32'hBFC00000, 32'h3C03BFC0, 4'hF, 32'h0,        32'd1, 1'b0};
      tbl[1]  = '{1'b0, 32'hBFC00000, 32'h0,        4'hF, 32'h3C03BFC0, 32'd1, 1'b0};
      tbl[2]  = '{1'b1, 32'h00000010, 32'h11223344, 4'hF, 32'h0,        32'd1, 1'b0};
      tbl[3]  = '{1'b1, 32'h00000010, 32'hAABBCCDD, 4'h5, 32'h0,        32'd1, 1'b0};
      tbl[4]  = '{1'b0, 32'h00000010, 32'h0,        4'hF, 32'h11BB33DD, 32'd1, 1'b0};
      tbl[5]  = '{1'b1, 32'h00000010, 32'hFFFFFFFF, 4'h0, 32'h0,        32'd1, 1'b0};
      tbl[6]  = '{1'b0, 32'h00000010, 32'h0,        4'hF, 32'h11BB33DD, 32'd1, 1'b0};
      tbl[7]  = '{1'b1, 32'h00000000, 32'h55AA55AA, 4'hF, 32'h0,        32'd1, 1'b0};
      tbl[8]  = '{1'b0, 32'hBFC00000, 32'h0,        4'hF, 32'h3C03BFC0, 32'd1, 1'b0};
      tbl[9]  = '{1'b0, 32'h00000000, 32'h0,        4'hF, 32'h55AA55AA, 32'd1, 1'b0};
      tbl[10] = '{1'b1, 32'hBFC01FFC, 32'hCAFEF00D, 4'hF, 32'h0,        32'd1, 1'b0};
      tbl[11] = '{1'b0, 32'hBFC01FFC, 32'h0,        4'hF, 32'hCAFEF00D, 32'd1, 1'b0};
      tbl[12] = '{1'b1, 32'h00001FFC, 32'h0BADF00D, 4'hF, 32'h0,        32'd1, 1'b0};
      tbl[13] = '{1'b0, 32'h00001FFC, 32'h0,        4'hF, 32'h0BADF00D, 32'd1, 1'b0};
      tbl[14] = '{1'b1, 32'h00000010, 32'h0000EE00, 4'h2, 32'h0,        32'd1, 1'b0};
      tbl[15] = '{1'b0, 32'h00000010, 32'h0,        4'hF, 32'h11BBEEDD, 32'd1, 1'b0};
      tbl[16] = '{1'b0, 32'h00000012, 32'h0,        4'hF, 32'h0,        32'd1, 1'b1};
      tbl[17] = '{1'b1, 32'h00000011, 32'hFFFFFFFF, 4'hF, 32'h0,        32'd1, 1'b1};
      tbl[18] = '{1'b0, 32'h00000010, 32'h0,        4'hF, 32'h11BBEEDD, 32'd1, 1'b1};
      tbl[19] = '{1'b0, 32'h00004000, 32'h0,        4'hF, 32'h0,        32'd1, 1'b1};
      tbl[20] = '{1'b0, 32'hBFC02000, 32'h0,        4'hF, 32'h0,        32'd1, 1'b1};
      tbl[21] = '{1'b0, 32'h00002000, 32'h0,        4'hF, 32'h0,        32'd1, 1'b1};
      for (int i = 0; i < 22; i++) begin
         if (!tbl[i].is_wr) exp_q.push_back(tbl[i].rdata);
         bus_op(tbl[i].is_wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, waits);
         check($sformatf("vec%0d_waits", i), 32'(waits), tbl[i].waits);
         check($sformatf("vec%0d_err", i), {31'd0, err_s}, {31'd0, tbl[i].err});
      end

      // read and write together: held off in IDLE, error, no memory change
      apply_reset();
      check("post_reset_err", {31'd0, err_s}, 32'd0);
      addr_b = 32'h10; wdata_b = 32'h0; be_b = 4'hF; rd_b = 1'b1; wr_b = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("rw_wait_c%0d", c), {31'd0, wait_s}, 32'd1);
         check($sformatf("rw_state_c%0d", c), 32'(dbg_s.state), 32'(IDLE));
      end
      check("rw_err", {31'd0, err_s}, 32'd1);
      @(posedge clk);
      #1 rd_b = 1'b0; wr_b = 1'b0;
      exp_q.push_back(32'h11BBEEDD);
      bus_op(1'b0, 32'h10, 32'h0, 4'hF, waits);

      // fixed 3-cycle stalls: 4 cycles of waitrequest per transfer
      sel = 1;
      bus_op(1'b1, 32'h20, 32'h01020304, 4'hF, waits);
      check("stall3_write_waits", 32'(waits), 32'd4);
      exp_q.push_back(32'h01020304);
      bus_op(1'b0, 32'h20, 32'h0, 4'hF, waits);
      check("stall3_read_waits", 32'(waits), 32'd4);
      check("stall3_err", {31'd0, err_s}, 32'd0);

      // write dropped mid-stall: abort to IDLE with error, memory untouched
      addr_b = 32'h20; wdata_b = 32'hFFFFFFFF; be_b = 4'hF; wr_b = 1'b1;
      @(posedge clk);
      #1 wr_b = 1'b0;
      check("drop_in_stall", 32'(dbg_s.state), 32'(STALL));
      @(posedge clk);
      #1;
      check("drop_state", 32'(dbg_s.state), 32'(IDLE));
      check("drop_err", {31'd0, err_s}, 32'd1);
      exp_q.push_back(32'h01020304);
      bus_op(1'b0, 32'h20, 32'h0, 4'hF, waits);
      check("drop_read_waits", 32'(waits), 32'd4);

      // reset asserted during the stall of a write
      apply_reset();
      exp_q.push_back(32'h01020304);
      bus_op(1'b0, 32'h20, 32'h0, 4'hF, waits);
      addr_b = 32'h20; wdata_b = 32'hDEADBEEF; be_b = 4'hF; wr_b = 1'b1;
      @(posedge clk);
      #1;
      check("rststall_state", 32'(dbg_s.state), 32'(STALL));
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rststall_wait", {31'd0, wait_s}, 32'd0);
      check("rststall_fsm", 32'(dbg_s.state), 32'(IDLE));
      @(posedge clk);
      #1 wr_b = 1'b0;
      #1 rst = 1'b0;
      last_rd[1] = '0;
      #1;
      check("rststall_err", {31'd0, err_s}, 32'd0);
      check("rststall_rdata", rdata_s, 32'd0);
      @(posedge clk);
      #1;
      exp_q.push_back(32'h01020304);
      bus_op(1'b0, 32'h20, 32'h0, 4'hF, waits);

      // random stalls against a reference memory model
      sel = 2;
      pool[0] = 32'hBFC00000; pool[1] = 32'hBFC00004; pool[2] = 32'hBFC00FF0; pool[3] = 32'hBFC01FFC;
      pool[4] = 32'h00000000; pool[5] = 32'h00000004; pool[6] = 32'h00000100; pool[7] = 32'h00001FFC;
      for (int i = 0; i < 8; i++) begin
         model[i] = $urandom;
         bus_op(1'b1, pool[i], model[i], 4'hF, waits);
         check("rand_init_waits", 32'((waits >= 1) && (waits <= 8)), 32'd1);
      end
      for (int n = 0; n < 200; n++) begin
         k = $urandom_range(0, 7);
         if ($urandom_range(0, 1) == 1) begin
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            m  = model[k];
            for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = d[8*b +: 8];
            model[k] = m;
            bus_op(1'b1, pool[k], d, be, waits);
         end else begin
            exp_q.push_back(model[k]);
            bus_op(1'b0, pool[k], 32'h0, 4'hF, waits);
         end
         check($sformatf("rand%0d_waits", n), 32'((waits >= 1) && (waits <= 8)), 32'd1);
      end
      check("rand_err", {31'd0, err_s}, 32'd0);
      check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
